// File: rtl/sf_camera_pkg.sv
// Shared definitions for the SF camera capture path: frame controller state
// encoding, write address stride and the frame-controller status bit layout.
package sf_camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUF,
    ST_ACTIVATE,
    ST_READ,
    ST_WRITE,
    ST_RELEASE,
    ST_DONE
  } frame_state_t;

  // One 32-bit word per write, byte-addressed memory
  localparam int unsigned ADDR_INCR = 4;

  // Frame-controller status bits as seen in the wb_sf_camera register map
  localparam int unsigned STAT_BUSY_BIT       = 0;
  localparam int unsigned STAT_FRAME_DONE_BIT = 1;
  localparam int unsigned STAT_ABORTED_BIT    = 2;
  localparam int unsigned STAT_LINE_COUNT_LSB = 16;

endpackage

// File: rtl/sf_camera_frame_ctrl.sv
// Frame capture controller: drains camera line buffers from the ping-pong FIFO
// read side into a memory write port, counting lines up to the frame height.
module sf_camera_frame_ctrl
  import sf_camera_pkg::*;
#(
  parameter int LINE_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_continuous,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LINE_WIDTH-1:0] i_lines_per_frame,
  input  logic                  i_rfifo_ready,
  output logic                  o_rfifo_activate,
  input  logic [23:0]           i_rfifo_size,
  output logic                  o_rfifo_strobe,
  input  logic [31:0]           i_rfifo_data,
  output logic                  o_mem_stb,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_aborted,
  output logic [LINE_WIDTH-1:0] o_line_count
);

  frame_state_t          state;
  logic [LINE_WIDTH-1:0] lines_q;
  logic [23:0]           size_q;
  logic [23:0]           word_cnt;
  logic [LINE_WIDTH-1:0] lines_eff;
  logic [LINE_WIDTH-1:0] line_next;

  // A zero frame height still captures one line
  assign lines_eff = (i_lines_per_frame == '0) ? LINE_WIDTH'(1) : i_lines_per_frame;
  // Empty buffers are released without being counted as a line
  assign line_next = o_line_count + LINE_WIDTH'(size_q != 24'd0);

  // NOTE: all state and outputs are registers updated with non-blocking
  // assignments so every branch below reads the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      lines_q          <= '0;
      size_q           <= '0;
      word_cnt         <= '0;
      o_rfifo_activate <= 1'b0;
      o_rfifo_strobe   <= 1'b0;
      o_mem_stb        <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_data       <= '0;
      o_busy           <= 1'b0;
      o_frame_done     <= 1'b0;
      o_aborted        <= 1'b0;
      o_line_count     <= '0;
    end else begin
      o_rfifo_strobe <= 1'b0;
      o_frame_done   <= 1'b0;
      o_aborted      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_enable) begin
            o_mem_addr   <= i_base_addr;
            lines_q      <= lines_eff;
            o_line_count <= '0;
            word_cnt     <= '0;
            o_busy       <= 1'b1;
            state        <= ST_WAIT_BUF;
          end
        end

        ST_WAIT_BUF: begin
          if (!i_enable) begin
            o_aborted <= 1'b1;
            o_busy    <= 1'b0;
            state     <= ST_IDLE;
          end else if (i_rfifo_ready) begin
            o_rfifo_activate <= 1'b1;
            state            <= ST_ACTIVATE;
          end
        end

        ST_ACTIVATE: begin
          size_q   <= i_rfifo_size;
          word_cnt <= '0;
          if (i_rfifo_size == 24'd0) begin
            o_rfifo_activate <= 1'b0;
            state            <= ST_RELEASE;
          end else begin
            o_rfifo_strobe <= 1'b1;
            state          <= ST_READ;
          end
        end

        // The pop strobe is high during READ, so the head word is sampled on
        // the same edge that advances the FIFO and never overlaps a write.
        ST_READ: begin
          o_mem_data <= i_rfifo_data;
          word_cnt   <= word_cnt + 24'd1;
          o_mem_stb  <= 1'b1;
          state      <= ST_WRITE;
        end

        ST_WRITE: begin
          if (i_mem_ready) begin
            o_mem_stb  <= 1'b0;
            o_mem_addr <= o_mem_addr + ADDR_WIDTH'(ADDR_INCR);
            if (word_cnt == size_q) begin
              o_rfifo_activate <= 1'b0;
              state            <= ST_RELEASE;
            end else begin
              o_rfifo_strobe <= 1'b1;
              state          <= ST_READ;
            end
          end
        end

        ST_RELEASE: begin
          o_line_count <= line_next;
          if (line_next >= lines_q) begin
            o_frame_done <= 1'b1;
            state        <= ST_DONE;
          end else if (!i_enable) begin
            o_aborted <= 1'b1;
            o_busy    <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_WAIT_BUF;
          end
        end

        ST_DONE: begin
          if (i_continuous && i_enable) begin
            o_mem_addr   <= i_base_addr;
            lines_q      <= lines_eff;
            o_line_count <= '0;
            word_cnt     <= '0;
            state        <= ST_WAIT_BUF;
          end else begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sf_camera_frame_ctrl.sv
// Self-checking bench for sf_camera_frame_ctrl: a line-buffer FIFO model and a
// memory model stepped on the falling edge, compared against expected writes.
module tb_sf_camera_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_continuous = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic [15:0] i_lines_per_frame = '0;
  logic        i_rfifo_ready = 1'b0;
  logic        o_rfifo_activate;
  logic [23:0] i_rfifo_size = '0;
  logic        o_rfifo_strobe;
  logic [31:0] i_rfifo_data = '0;
  logic        o_mem_stb;
  logic        i_mem_ready = 1'b1;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_aborted;
  logic [15:0] o_line_count;

  sf_camera_frame_ctrl #(.LINE_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_enable          (i_enable),
    .i_continuous      (i_continuous),
    .i_base_addr       (i_base_addr),
    .i_lines_per_frame (i_lines_per_frame),
    .i_rfifo_ready     (i_rfifo_ready),
    .o_rfifo_activate  (o_rfifo_activate),
    .i_rfifo_size      (i_rfifo_size),
    .o_rfifo_strobe    (o_rfifo_strobe),
    .i_rfifo_data      (i_rfifo_data),
    .o_mem_stb         (o_mem_stb),
    .i_mem_ready       (i_mem_ready),
    .o_mem_addr        (o_mem_addr),
    .o_mem_data        (o_mem_data),
    .o_busy            (o_busy),
    .o_frame_done      (o_frame_done),
    .o_aborted         (o_aborted),
    .o_line_count      (o_line_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Line-buffer FIFO model
  int          fifo_sizes[$];
  logic [31:0] fifo_words[$];
  int          cur_size;
  bit          act_q;
  bit          pop_pending;

  // Memory model and observations
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_len[$];
  bit          held_q;
  logic [31:0] addr_q, data_q;
  int          cur_len, stall_left, stall_word, stall_len, stall_pct;
  int          strobe_cnt, done_cnt, abort_cnt, rule_viol;

  // Expected writes: frame base plus one word stride per stored word
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_next;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One falling-edge step: sample DUT outputs, then drive FIFO and memory inputs
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      act_q = 0; pop_pending = 0; held_q = 0; stall_left = 0; cur_len = 0;
      i_mem_ready = 1'b1; i_rfifo_ready = 1'b0; i_rfifo_size = '0; i_rfifo_data = '0;
    end else begin
      if (pop_pending) begin
        if (fifo_words.size() > 0) void'(fifo_words.pop_front());
        pop_pending = 0;
      end
      if (o_rfifo_activate && !act_q)
        cur_size = (fifo_sizes.size() > 0) ? fifo_sizes.pop_front() : 0;
      act_q         = o_rfifo_activate;
      i_rfifo_size  = o_rfifo_activate ? 24'(cur_size) : 24'd0;
      i_rfifo_data  = (o_rfifo_activate && fifo_words.size() > 0) ? fifo_words[0] : 32'd0;
      i_rfifo_ready = !o_rfifo_activate && (fifo_sizes.size() > 0);

      if (o_rfifo_strobe) begin
        strobe_cnt++;
        pop_pending = 1;
        if (!o_rfifo_activate || o_mem_stb) rule_viol++;
      end
      if (held_q && !o_mem_stb) rule_viol++;
      if (o_mem_stb) begin
        if (held_q && (o_mem_addr !== addr_q || o_mem_data !== data_q)) rule_viol++;
        if (!held_q && obs_addr.size() == stall_word) stall_left = stall_len;
        if (stall_left > 0) begin
          i_mem_ready = 1'b0;
          stall_left--;
        end else begin
          i_mem_ready = ($urandom_range(99, 0) >= stall_pct);
        end
        cur_len++;
        if (i_mem_ready) begin
          obs_addr.push_back(o_mem_addr);
          obs_data.push_back(o_mem_data);
          obs_len.push_back(cur_len);
          cur_len = 0;
        end
        held_q = !i_mem_ready;
        addr_q = o_mem_addr;
        data_q = o_mem_data;
      end else begin
        i_mem_ready = 1'b1;
        held_q = 0;
      end
      if (o_frame_done) done_cnt++;
      if (o_aborted) abort_cnt++;
    end
  endtask

  task automatic prep(input logic [31:0] base, input logic [15:0] lines, input bit cont);
    fifo_sizes.delete(); fifo_words.delete();
    obs_addr.delete(); obs_data.delete(); obs_len.delete();
    exp_addr.delete(); exp_data.delete();
    strobe_cnt = 0; done_cnt = 0; abort_cnt = 0; rule_viol = 0;
    stall_word = -1; stall_len = 0; stall_pct = 0;
    i_base_addr = base; i_lines_per_frame = lines; i_continuous = cont;
    exp_next = base;
  endtask

  task automatic add_line(input int size, input bit expected);
    logic [31:0] w;
    fifo_sizes.push_back(size);
    for (int k = 0; k < size; k++) begin
      w = $urandom();
      fifo_words.push_back(w);
      if (expected) begin
        exp_addr.push_back(exp_next);
        exp_data.push_back(w);
        exp_next = exp_next + 32'd4;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int max_cycles);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < max_cycles) begin
      tick();
      cyc++;
      if (o_frame_done) begin
        seen++;
        if (seen == n) i_enable = 1'b0;
      end
    end
    i_enable = 1'b0;
    check("frames_in_time", 64'(seen), 64'(n));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
    end
    check({tag, "_rules"}, 64'(rule_viol), 64'd0);
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  initial begin
    int cyc;
    int n_lines;

    // Reset values
    prep(32'h0, 16'd0, 1'b0);
    repeat (2) tick();
    check("rst_stb", 64'(o_mem_stb), 64'd0);
    check("rst_act", 64'(o_rfifo_activate), 64'd0);
    check("rst_addr", 64'(o_mem_addr), 64'd0);
    check("rst_flags", 64'({o_busy, o_frame_done, o_aborted, o_rfifo_strobe}), 64'd0);
    check("rst_lines", 64'(o_line_count), 64'd0);
    rst = 1'b0;
    tick();

    // Single shot, two 4-word lines, no backpressure
    prep(32'h0000_1000, 16'd2, 1'b0);
    add_line(4, 1); add_line(4, 1);
    tick();
    i_enable = 1'b1;
    tick();
    check("busy_latency", 64'(o_busy), 64'd1);
    tick();
    check("activate_latency", 64'(o_rfifo_activate), 64'd1);
    wait_frames(1, 200);
    settle();
    check_writes("single");
    check("single_strobes", 64'(strobe_cnt), 64'd8);
    check("single_done", 64'(done_cnt), 64'd1);
    check("single_lines", 64'(o_line_count), 64'd2);
    check("single_busy", 64'(o_busy), 64'd0);
    check("single_abort", 64'(abort_cnt), 64'd0);

    // Backpressure: three stall cycles on the second word
    prep(32'h0000_4000, 16'd1, 1'b0);
    add_line(4, 1);
    stall_word = 1; stall_len = 3;
    i_enable = 1'b1;
    wait_frames(1, 200);
    settle();
    check_writes("bp");
    check("bp_strobes", 64'(strobe_cnt), 64'd4);
    check("bp_word2_len", 64'((obs_len.size() > 1) ? obs_len[1] : 0), 64'd4);
    check("bp_word1_len", 64'((obs_len.size() > 0) ? obs_len[0] : 0), 64'd1);

    // Random sizes and random backpressure over a 3-line frame
    prep($urandom() & 32'hFFFF_FFFC, 16'd3, 1'b0);
    for (int l = 0; l < 3; l++) add_line(int'($urandom_range(5, 1)), 1);
    stall_pct = 40;
    i_enable = 1'b1;
    wait_frames(1, 400);
    settle();
    check_writes("rand");
    check("rand_strobes", 64'(strobe_cnt), 64'(exp_addr.size()));
    check("rand_lines", 64'(o_line_count), 64'd3);

    // Enable dropped during buffer 1 of 3: buffer drains, frame aborts
    prep(32'h0000_8000, 16'd3, 1'b0);
    add_line(3, 1); add_line(3, 0); add_line(3, 0);
    i_enable = 1'b1;
    cyc = 0;
    while (!o_rfifo_strobe && cyc < 100) begin tick(); cyc++; end
    i_enable = 1'b0;
    cyc = 0;
    while (!o_aborted && cyc < 100) begin tick(); cyc++; end
    check("abort_seen", 64'(o_aborted), 64'd1);
    settle();
    check_writes("abort");
    check("abort_cnt", 64'(abort_cnt), 64'd1);
    check("abort_done", 64'(done_cnt), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_act", 64'(o_rfifo_activate), 64'd0);
    check("abort_lines", 64'(o_line_count), 64'd1);

    // Continuous mode, one line per frame, three frames from the same base
    prep(32'h2000_0000, 16'd1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      exp_next = 32'h2000_0000;
      add_line(2, 1);
    end
    i_enable = 1'b1;
    wait_frames(3, 300);
    settle();
    check_writes("cont");
    check("cont_done", 64'(done_cnt), 64'd3);
    check("cont_busy", 64'(o_busy), 64'd0);

    // Empty buffer is released without counting a line
    prep(32'h0000_C000, 16'd2, 1'b0);
    add_line(0, 1); add_line(2, 1); add_line(2, 1);
    i_enable = 1'b1;
    wait_frames(1, 200);
    settle();
    check_writes("zero");
    check("zero_lines", 64'(o_line_count), 64'd2);
    check("zero_done", 64'(done_cnt), 64'd1);

    // Frame height 0 behaves as a single line
    prep(32'h0000_D000, 16'd0, 1'b0);
    add_line(3, 1); add_line(3, 0);
    i_enable = 1'b1;
    wait_frames(1, 200);
    settle();
    check_writes("h0");
    check("h0_lines", 64'(o_line_count), 64'd1);
    check("h0_done", 64'(done_cnt), 64'd1);

    // Address wraps past the top of the address space
    prep(32'hFFFF_FFFC, 16'd1, 1'b0);
    add_line(2, 1);
    i_enable = 1'b1;
    wait_frames(1, 200);
    settle();
    check_writes("wrap");
    n_lines = obs_addr.size();
    check("wrap_second", 64'((n_lines > 1) ? obs_addr[1] : 32'hDEAD_BEEF), 64'h0);

    // Asynchronous reset while a write is stalled
    prep(32'h0000_E000, 16'd1, 1'b0);
    add_line(4, 1);
    stall_word = 0; stall_len = 1000;
    i_enable = 1'b1;
    cyc = 0;
    while (!o_mem_stb && cyc < 100) begin tick(); cyc++; end
    check("rst_mid_stb_before", 64'(o_mem_stb), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_stb", 64'(o_mem_stb), 64'd0);
    check("arst_act", 64'(o_rfifo_activate), 64'd0);
    check("arst_addr", 64'(o_mem_addr), 64'd0);
    check("arst_data", 64'(o_mem_data), 64'd0);
    check("arst_flags", 64'({o_busy, o_frame_done, o_aborted, o_rfifo_strobe}), 64'd0);
    check("arst_lines", 64'(o_line_count), 64'd0);
    i_enable = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_busy", 64'(o_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
